// File: rtl/nubus_host_bridge.sv
// rtl/nubus_host_bridge.sv - CPU-to-NuBus minor slot space initiator with timeout and slot interrupt sync
module nubus_host_bridge #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned SLOT_BASE = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cpu_addr,
  input  logic [15:0] cpu_data_in,
  output logic [15:0] cpu_data_out,
  input  logic [1:0]  cpu_uds_lds,
  input  logic        cpu_rw_n,
  input  logic        cpu_as,
  input  logic        cpu_sel,
  output logic        cpu_dtack_n,
  output logic        cpu_berr_n,
  output logic [31:0] nb_addr,
  output logic [15:0] nb_data_out,
  output logic [1:0]  nb_uds_lds,
  output logic        nb_rw_n,
  output logic [5:0]  nb_select,
  input  logic [95:0] nb_data_in,
  input  logic [5:0]  nb_ack_n,
  input  logic [5:0]  nb_nmrq_n,
  output logic [5:0]  slot_irq_status,
  output logic        slot_irq_n
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE,
    ST_RECOVER,
    ST_ERR
  } state_t;

  localparam logic [3:0]  LP_BASE     = 4'(SLOT_BASE);
  localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic [2:0]  r_slot;
  logic [15:0] r_timer;
  logic [5:0]  r_sync1;
  logic [5:0]  r_sync2;
  logic        r_irq_n;

  logic [3:0]  w_slot4;
  logic        w_hit;
  logic        w_ack_n;
  logic [15:0] w_rdata;

  // Slot index wraps in 4 bits, so slots below SLOT_BASE land far out of range and miss.
  assign w_slot4 = cpu_addr[27:24] - LP_BASE;
  assign w_hit   = (cpu_addr[31:28] == 4'hF) && (w_slot4 < 4'd6);
  assign w_ack_n = nb_ack_n[r_slot];
  assign w_rdata = nb_data_in[{r_slot, 4'b0000} +: 16];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_slot       <= 3'd0;
      r_timer      <= 16'd0;
      cpu_data_out <= 16'd0;
      cpu_dtack_n  <= 1'b1;
      cpu_berr_n   <= 1'b1;
      nb_addr      <= 32'd0;
      nb_data_out  <= 16'd0;
      nb_uds_lds   <= 2'b00;
      nb_rw_n      <= 1'b1;
      nb_select    <= 6'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cpu_as && cpu_sel) begin
            if (w_hit) begin
              r_slot      <= w_slot4[2:0];
              r_timer     <= 16'd0;
              nb_addr     <= cpu_addr;
              nb_data_out <= cpu_data_in;
              nb_uds_lds  <= cpu_uds_lds;
              nb_rw_n     <= cpu_rw_n;
              nb_select   <= 6'd1 << w_slot4[2:0];
              r_state     <= ST_REQ;
            end else begin
              cpu_berr_n <= 1'b0;
              r_state    <= ST_ERR;
            end
          end
        end
        ST_REQ: begin
          if (!cpu_as) begin
            nb_select <= 6'd0;
            r_state   <= ST_RECOVER;
          end else if (!w_ack_n) begin
            if (nb_rw_n) begin
              cpu_data_out <= w_rdata;
            end
            nb_select   <= 6'd0;
            cpu_dtack_n <= 1'b0;
            r_state     <= ST_DONE;
          end else if (r_timer == LP_TMO_LAST) begin
            nb_select    <= 6'd0;
            cpu_data_out <= 16'hFFFF;
            cpu_berr_n   <= 1'b0;
            r_state      <= ST_ERR;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        ST_DONE: begin
          if (!cpu_as) begin
            cpu_dtack_n <= 1'b1;
            r_state     <= ST_RECOVER;
          end
        end
        // The card must release ack before another select is issued.
        ST_RECOVER: begin
          if (w_ack_n) begin
            r_state <= ST_IDLE;
          end
        end
        ST_ERR: begin
          if (!cpu_as) begin
            cpu_berr_n <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          nb_select <= 6'd0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 6'h3F;
      r_sync2 <= 6'h3F;
      r_irq_n <= 1'b1;
    end else begin
      r_sync1 <= nb_nmrq_n;
      r_sync2 <= r_sync1;
      r_irq_n <= &r_sync2;
    end
  end

  assign slot_irq_status = ~r_sync2;
  assign slot_irq_n      = r_irq_n;

endmodule
